// File: rtl/whackamole_pkg.sv
// Shared definitions for the whack-a-mole display path.
//   conv_state_e  : states of the sequential binary-to-BCD converter
//   SEG_*         : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   digit_to_seg  : BCD nibble to segment code, blank for non-decimal nibbles
package whackamole_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] code;
        code = SEG_BLANK;
        if (d <= 4'd9) begin
            code = SEG_DIGIT[d];
        end
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock.
//   clock, reset : system clock, synchronous active-high reset
//   start        : request a conversion of bin (sampled only while idle)
//   bin          : binary value; values above 99 saturate to 99
//   busy         : high in LOAD and SHIFT
//   done         : high for the single DONE cycle in which tens/ones update
//   tens, ones   : last completed result, updated together so no partial value is ever seen
module bin2bcd_seq
    import whackamole_pkg::*;
#(
    parameter int unsigned SCORE_W = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done,
    output logic [3:0]         tens,
    output logic [3:0]         ones
);

    localparam int unsigned SHW   = SCORE_W + 8;
    localparam int unsigned CNT_W = $clog2(SCORE_W + 1);

    conv_state_e        state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [SHW-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         tens_q, tens_d;
    logic [3:0]         ones_q, ones_d;

    logic [SCORE_W-1:0] sat;
    logic [SHW-1:0]     adj;
    logic [SHW-1:0]     shifted;

    always_comb begin
        sat = bin_q;
        if (32'(bin_q) > 32'd99) begin
            sat = SCORE_W'(99);
        end
    end

    // One double-dabble step: correct each BCD nibble >= 5, then shift.
    always_comb begin
        adj = shreg_q;
        if (adj[SCORE_W+4 +: 4] >= 4'd5) begin
            adj[SCORE_W+4 +: 4] = adj[SCORE_W+4 +: 4] + 4'd3;
        end
        if (adj[SCORE_W +: 4] >= 4'd5) begin
            adj[SCORE_W +: 4] = adj[SCORE_W +: 4] + 4'd3;
        end
        shifted = {adj[SHW-2:0], 1'b0};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shreg_d = {8'b0, sat};
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                shreg_d = shifted;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(SCORE_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                tens_d  = shreg_q[SCORE_W+4 +: 4];
                ones_d  = shreg_q[SCORE_W +: 4];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign busy = (state_q == LOAD) || (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign tens = tens_q;
    assign ones = ones_q;

endmodule

// File: rtl/score_display_driver.sv
// Drives a 4-digit common-anode 7-segment display from the game score and status.
//   clock, reset : 100MHz clock, synchronous active-high reset
//   tick_in      : 1kHz square wave; each rising edge advances the scan by one digit
//   score        : binary score, converted to two BCD digits
//   game_active  : game running, shows 'P' in the leftmost digit
//   game_over    : timer expired, shows 'E' and blinks the whole display
//   seg          : active-low segments {g,f,e,d,c,b,a}
//   an           : active-low anode enables, an[0] is the rightmost digit
//   conv_busy    : BCD conversion in progress
module score_display_driver
    import whackamole_pkg::*;
#(
    parameter int unsigned SCORE_W     = 6,
    parameter int unsigned BLINK_TICKS = 500
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_in,
    input  logic [SCORE_W-1:0] score,
    input  logic               game_active,
    input  logic               game_over,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               conv_busy
);

    localparam int unsigned BC_W = $clog2(BLINK_TICKS + 1);

    logic               tick_q;
    logic               scan_en;
    logic [1:0]         scan_idx_q, scan_idx_d;
    logic [BC_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               blink_off_q, blink_off_d;
    logic [SCORE_W-1:0] last_score_q, last_score_d;
    logic [SCORE_W-1:0] pend_q, pend_d;
    logic [6:0]         seg_q, seg_d;
    logic [3:0]         an_q, an_d;

    logic               start;
    logic               conv_done;
    logic [3:0]         bcd_tens;
    logic [3:0]         bcd_ones;
    logic [1:0]         shown_idx;
    logic [6:0]         glyph;

    assign scan_en = tick_in & ~tick_q;
    assign start   = (score != last_score_q);

    bin2bcd_seq #(
        .SCORE_W(SCORE_W)
    ) u_bin2bcd (
        .clock(clock),
        .reset(reset),
        .start(start),
        .bin  (score),
        .busy (conv_busy),
        .done (conv_done),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

    // The converter samples score only while idle; remember that value so it becomes
    // last_score exactly when its result lands.
    always_comb begin
        pend_d       = pend_q;
        last_score_d = last_score_q;
        if (start && !conv_busy && !conv_done) begin
            pend_d = score;
        end
        if (conv_done) begin
            last_score_d = pend_q;
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_off_d = blink_off_q;
        if (!game_over) begin
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
        end else if (scan_en) begin
            if (blink_cnt_q == BC_W'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_off_d = ~blink_off_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // scan_idx names the next digit to light; the lit digit is the one before it.
    always_comb begin
        scan_idx_d = scan_idx_q;
        an_d       = an_q;
        shown_idx  = scan_idx_q - 2'd1;
        if (scan_en) begin
            scan_idx_d = scan_idx_q + 2'd1;
            an_d       = ~(4'b0001 << scan_idx_q);
            shown_idx  = scan_idx_q;
        end
    end

    always_comb begin
        glyph = SEG_BLANK;
        case (shown_idx)
            2'd0: glyph = digit_to_seg(bcd_ones);
            2'd1: glyph = (bcd_tens == 4'd0) ? SEG_BLANK : digit_to_seg(bcd_tens);
            2'd2: glyph = SEG_BLANK;
            2'd3: begin
                if (game_over) begin
                    glyph = SEG_E;
                end else if (game_active) begin
                    glyph = SEG_P;
                end else begin
                    glyph = SEG_DASH;
                end
            end
            default: glyph = SEG_BLANK;
        endcase
        // Using the next blink state lets the display recover on the edge game_over drops.
        seg_d = (an_d == 4'hF || blink_off_d) ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q       <= 1'b0;
            scan_idx_q   <= '0;
            blink_cnt_q  <= '0;
            blink_off_q  <= 1'b0;
            last_score_q <= '0;
            pend_q       <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= 4'hF;
        end else begin
            tick_q       <= tick_in;
            scan_idx_q   <= scan_idx_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_off_q  <= blink_off_d;
            last_score_q <= last_score_d;
            pend_q       <= pend_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
